// File: rtl/sseg_scan_scheduler_if.sv
// Bus bundle for the seven-segment scan scheduler.
//   master : side that writes display values and consumes the scan outputs
//   slave  : the scheduler itself
// Signals:
//   wr_en        1-cycle strobe, capture wr_data into the shadow register
//   wr_data      four hex digits, [3:0]=digit0 (rightmost) .. [15:12]=digit3
//   digit_en     per-digit enable, bit i gates an[i]
//   lz_suppress  blank leading zero digits (digit0 never suppressed)
//   an           active-low anode drive, at most one bit low
//   hex_digit    nibble for the shared hex-to-7-segment decoder
//   frame_start  1-cycle pulse at the start of each new frame
//   upd_pending  shadow holds data not yet moved to the active register
interface sseg_scan_scheduler_if;
   logic        wr_en;
   logic [15:0] wr_data;
   logic [3:0]  digit_en;
   logic        lz_suppress;
   logic [3:0]  an;
   logic [3:0]  hex_digit;
   logic        frame_start;
   logic        upd_pending;

   modport master (
      output wr_en, wr_data, digit_en, lz_suppress,
      input  an, hex_digit, frame_start, upd_pending
   );

   modport slave (
      input  wr_en, wr_data, digit_en, lz_suppress,
      output an, hex_digit, frame_start, upd_pending
   );
endinterface

// File: rtl/sseg_scan_scheduler.sv
// Scan controller for a 4-digit multiplexed seven-segment display.
// Sequences the digits in fixed-length slots, blanks the anodes at the start of
// every slot to avoid ghosting, applies digit masking and leading-zero
// suppression, and swaps in new display values only at frame boundaries.
// Ports:
//   clk    system clock, all state on the rising edge
//   reset  asynchronous, active-low
//   bus    sseg_scan_scheduler_if.slave (write port, enables, scan outputs)
// Parameters:
//   SLOT_CYC   clk cycles per digit slot (>= 2)
//   BLANK_CYC  blank cycles at the start of each slot (1 <= BLANK_CYC < SLOT_CYC)
module sseg_scan_scheduler #(
   parameter int SLOT_CYC  = 100000,
   parameter int BLANK_CYC = 2000
) (
   input  logic                  clk,
   input  logic                  reset,
   sseg_scan_scheduler_if.slave  bus
);

   localparam int              CW        = $clog2(SLOT_CYC);
   localparam logic [CW-1:0]   CNT_LAST  = CW'(SLOT_CYC - 1);
   localparam logic [CW-1:0]   CNT_SHOW  = CW'(BLANK_CYC);

   localparam logic [0:0]      ST_BLANK  = 1'b0;
   localparam logic [0:0]      ST_SHOW   = 1'b1;

   logic [CW-1:0] cnt_reg,    cnt_next;
   logic [1:0]    idx_reg,    idx_next;
   logic [0:0]    state_reg,  state_next;
   logic [15:0]   shadow_reg;
   logic [15:0]   active_reg;
   logic          pending_reg;
   logic [3:0]    an_reg,     an_next;
   logic [3:0]    hex_reg,    hex_next;
   logic          fs_reg;

   logic          cnt_wrap;
   logic          frame_end;
   logic [3:0]    visible;
   logic [3:0]    nibble [4];

   // Slot/digit sequencing. Wrap is detected by compare so SLOT_CYC need not
   // be a power of two.
   assign cnt_wrap  = (cnt_reg == CNT_LAST);
   assign frame_end = cnt_wrap && (idx_reg == 2'd3);

   always_comb begin
      cnt_next = cnt_wrap ? '0 : cnt_reg + 1'b1;
      idx_next = idx_reg;
      if (cnt_wrap) begin
         idx_next = (idx_reg == 2'd3) ? 2'd0 : idx_reg + 2'd1;
      end
      // State tracks the slot counter: it always describes cnt_reg.
      state_next = (cnt_next < CNT_SHOW) ? ST_BLANK : ST_SHOW;
   end

   // Per-digit nibble and visibility. A digit is a leading zero when it and
   // every digit to its left are zero; digit0 is always eligible.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_digit
         assign nibble[gi] = active_reg[4*gi +: 4];
         if (gi == 0) begin : g_first
            assign visible[gi] = bus.digit_en[gi];
         end else begin : g_upper
            assign visible[gi] = bus.digit_en[gi] &&
                                 !(bus.lz_suppress && (active_reg[15:4*gi] == '0));
         end
      end
   endgenerate

   // Output decode. An invisible digit keeps its full slot with anodes off so
   // the duty cycle of every digit is constant; hex_digit still carries the
   // nibble during SHOW.
   always_comb begin
      an_next  = 4'b1111;
      hex_next = 4'h0;
      if (state_reg == ST_SHOW) begin
         hex_next = nibble[idx_reg];
         if (visible[idx_reg]) begin
            an_next[idx_reg] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_reg     <= '0;
         idx_reg     <= 2'd0;
         state_reg   <= ST_BLANK;
         shadow_reg  <= 16'h0;
         active_reg  <= 16'h0;
         pending_reg <= 1'b0;
         an_reg      <= 4'b1111;
         hex_reg     <= 4'h0;
         fs_reg      <= 1'b0;
      end else begin
         cnt_reg   <= cnt_next;
         idx_reg   <= idx_next;
         state_reg <= state_next;
         an_reg    <= an_next;
         hex_reg   <= hex_next;
         fs_reg    <= frame_end;

         if (bus.wr_en) begin
            shadow_reg <= bus.wr_data;
         end

         // Active only changes on the last cycle of the frame; a write landing
         // on that very cycle bypasses the shadow and never raises pending.
         if (frame_end) begin
            pending_reg <= 1'b0;
            if (bus.wr_en) begin
               active_reg <= bus.wr_data;
            end else if (pending_reg) begin
               active_reg <= shadow_reg;
            end
         end else if (bus.wr_en) begin
            pending_reg <= 1'b1;
         end
      end
   end

   assign bus.an          = an_reg;
   assign bus.hex_digit   = hex_reg;
   assign bus.frame_start = fs_reg;
   assign bus.upd_pending = pending_reg;

endmodule

// File: tb/tb_sseg_scan_scheduler.sv
module tb_sseg_scan_scheduler;

   localparam int SLOT  = 8;
   localparam int BLANK = 2;
   localparam int FRAME = 4 * SLOT;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_errors;

   sseg_scan_scheduler_if bus_if ();

   sseg_scan_scheduler #(
      .SLOT_CYC  (SLOT),
      .BLANK_CYC (BLANK)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one clock and sample 1 ns after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Run one full frame starting with the DUT at digit0, cnt=0.
   // shown : active value expected on display this frame
   // vis   : hand-computed visible mask for this frame
   // wN_pos: slot-cycle position (0..31) at which to pulse wr_en, -1 for none
   task automatic run_frame(input string tag, input logic [15:0] shown, input logic [3:0] vis,
                            input int w1_pos, input logic [15:0] w1_val,
                            input int w2_pos, input logic [15:0] w2_val);
      logic       pend;
      logic [3:0] exp_an;
      logic [3:0] exp_hex;
      int         slot;
      int         c;
      pend = 1'b0;
      for (int i = 0; i < FRAME; i++) begin
         bus_if.wr_en = 1'b0;
         if (i == w1_pos) begin
            bus_if.wr_en = 1'b1; bus_if.wr_data = w1_val;
         end
         if (i == w2_pos) begin
            bus_if.wr_en = 1'b1; bus_if.wr_data = w2_val;
         end
         if (bus_if.wr_en && i != FRAME - 1) pend = 1'b1;
         if (i == FRAME - 1) pend = 1'b0;
         step();
         slot    = i / SLOT;
         c       = i % SLOT;
         exp_an  = 4'b1111;
         exp_hex = 4'h0;
         if (c >= BLANK) begin
            exp_hex = shown[4*slot +: 4];
            if (vis[slot]) exp_an[slot] = 1'b0;
         end
         check_eq($sformatf("%s an @%0d", tag, i), {12'h0, bus_if.an}, {12'h0, exp_an});
         check_eq($sformatf("%s hex @%0d", tag, i), {12'h0, bus_if.hex_digit}, {12'h0, exp_hex});
         check_eq($sformatf("%s fs @%0d", tag, i), {15'h0, bus_if.frame_start},
                  {15'h0, (i == FRAME - 1)});
         check_eq($sformatf("%s pend @%0d", tag, i), {15'h0, bus_if.upd_pending}, {15'h0, pend});
      end
      bus_if.wr_en = 1'b0;
      $display("frame %-10s shown=%h vis=%b", tag, shown, vis);
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      reset              = 1'b0;
      bus_if.wr_en       = 1'b0;
      bus_if.wr_data     = 16'h0;
      bus_if.digit_en    = 4'b1111;
      bus_if.lz_suppress = 1'b0;

      // Reset state
      #23;
      check_eq("rst an",   {12'h0, bus_if.an},          16'h000F);
      check_eq("rst hex",  {12'h0, bus_if.hex_digit},   16'h0000);
      check_eq("rst fs",   {15'h0, bus_if.frame_start}, 16'h0000);
      check_eq("rst pend", {15'h0, bus_if.upd_pending}, 16'h0000);
      reset = 1'b1;   // released mid-period, away from the edge

      // 1: free-running scan, no writes
      run_frame("idle0", 16'h0000, 4'b1111, -1, 16'h0, -1, 16'h0);
      run_frame("idle1", 16'h0000, 4'b1111, -1, 16'h0, -1, 16'h0);

      // 2: mid-frame write (digit1 slot) applies at the next frame
      run_frame("wr1234", 16'h0000, 4'b1111, 12, 16'h1234, -1, 16'h0);
      run_frame("sh1234", 16'h1234, 4'b1111, -1, 16'h0, -1, 16'h0);

      // 3: leading-zero suppression
      bus_if.lz_suppress = 1'b1;
      run_frame("wr00A0", 16'h1234, 4'b1111, 5, 16'h00A0, -1, 16'h0);
      run_frame("sh00A0", 16'h00A0, 4'b0011, 3, 16'h0000, -1, 16'h0);
      run_frame("sh0000", 16'h0000, 4'b0001, -1, 16'h0, -1, 16'h0);

      // 4: digit masking
      bus_if.lz_suppress = 1'b0;
      bus_if.digit_en    = 4'b0101;
      run_frame("mask0", 16'h0000, 4'b0101, 0, 16'h1234, -1, 16'h0);
      run_frame("mask1", 16'h1234, 4'b0101, -1, 16'h0, -1, 16'h0);

      // 5: last write wins; write exactly on the boundary bypasses shadow
      bus_if.digit_en = 4'b1111;
      run_frame("wrAB", 16'h1234, 4'b1111, 4, 16'hAAAA, 9, 16'hBBBB);
      run_frame("shBB", 16'hBBBB, 4'b1111, FRAME - 1, 16'hCCCC, -1, 16'h0);
      run_frame("shCC", 16'hCCCC, 4'b1111, -1, 16'h0, -1, 16'h0);

      // 6: asynchronous reset during digit2 SHOW with a pending write
      for (int i = 0; i < 20; i++) begin
         bus_if.wr_en   = (i == 18);
         bus_if.wr_data = 16'h5555;
         step();
      end
      bus_if.wr_en = 1'b0;
      check_eq("pre-rst an",   {12'h0, bus_if.an},          16'h000B);
      check_eq("pre-rst pend", {15'h0, bus_if.upd_pending}, 16'h0001);
      #2;
      reset = 1'b0;
      #1;
      check_eq("arst an",   {12'h0, bus_if.an},          16'h000F);
      check_eq("arst hex",  {12'h0, bus_if.hex_digit},   16'h0000);
      check_eq("arst pend", {15'h0, bus_if.upd_pending}, 16'h0000);
      #3;
      reset = 1'b1;
      run_frame("post0", 16'h0000, 4'b1111, -1, 16'h0, -1, 16'h0);
      run_frame("post1", 16'h0000, 4'b1111, -1, 16'h0, -1, 16'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
